// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-path PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    OFFER,
    WAIT_COMMIT
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h3000_0000;
  localparam int          DEFAULT_INST_BYTES   = 4;

  // A single channel still needs a one-bit index field.
  function automatic int redir_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_redir_arbiter.sv
// Fixed-priority redirect select: lowest asserted channel index wins.
module redir_arbiter
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REDIR  = 2,
  parameter int IDX_W      = redir_idx_w(NUM_REDIR)
) (
  input  logic [NUM_REDIR-1:0]            redir_valid,
  input  logic [NUM_REDIR*DATA_WIDTH-1:0] redir_target,
  output logic                            any_valid,
  output logic [IDX_W-1:0]                win_idx,
  output logic [DATA_WIDTH-1:0]           win_target
);

  always_comb begin
    any_valid  = 1'b0;
    win_idx    = '0;
    win_target = '0;
    // Scan high to low so the last hit is the lowest index.
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        any_valid  = 1'b1;
        win_idx    = IDX_W'(i);
        win_target = redir_target[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC holder: offers pc to the IFU, advances on commit to a
// prioritised redirect target or the sequential next instruction.
//
// state       | meaning
// BOOT        | first cycle after reset, pc = reset vector, not yet offered
// OFFER       | pc_valid high, waiting for the IFU to accept
// WAIT_COMMIT | pc accepted, holding until commit; redirects are captured
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                    INST_BYTES   = DEFAULT_INST_BYTES,
  parameter int                    NUM_REDIR    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            commit,
  input  logic [NUM_REDIR-1:0]            redir_valid,
  input  logic [NUM_REDIR*DATA_WIDTH-1:0] redir_target,
  output logic [DATA_WIDTH-1:0]           pc,
  output logic                            pc_valid,
  input  logic                            pc_ready,
  output logic                            epoch,
  output logic                            misalign
);

  localparam int                    IDX_W    = redir_idx_w(NUM_REDIR);
  localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(INST_BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(INST_BYTES);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic                    pc_valid_q, pc_valid_d;
  logic                    epoch_q, epoch_d;
  logic                    misalign_q, misalign_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]        pend_idx_q, pend_idx_d;
  logic [DATA_WIDTH-1:0]   pend_target_q, pend_target_d;

  logic                    any_valid;
  logic [IDX_W-1:0]        win_idx;
  logic [DATA_WIDTH-1:0]   win_target;
  logic                    apply_en;
  logic [DATA_WIDTH-1:0]   apply_tgt;

  redir_arbiter #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REDIR (NUM_REDIR),
    .IDX_W     (IDX_W)
  ) u_arb (
    .redir_valid (redir_valid),
    .redir_target(redir_target),
    .any_valid   (any_valid),
    .win_idx     (win_idx),
    .win_target  (win_target)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_valid_d    = pc_valid_q;
    epoch_d       = epoch_q;
    misalign_d    = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_idx_d    = pend_idx_q;
    pend_target_d = pend_target_q;
    apply_en      = 1'b0;
    apply_tgt     = '0;

    case (state_q)
      BOOT: begin
        state_d    = OFFER;
        pc_valid_d = 1'b1;
        if (any_valid) begin
          apply_en  = 1'b1;
          apply_tgt = win_target;
        end
      end
      OFFER: begin
        // A redirect cancels a same-cycle handshake.
        if (any_valid) begin
          apply_en  = 1'b1;
          apply_tgt = win_target;
        end else if (pc_ready) begin
          state_d    = WAIT_COMMIT;
          pc_valid_d = 1'b0;
        end
      end
      WAIT_COMMIT: begin
        if (commit) begin
          state_d      = OFFER;
          pc_valid_d   = 1'b1;
          pend_valid_d = 1'b0;
          if (any_valid && (!pend_valid_q || win_idx <= pend_idx_q)) begin
            apply_en  = 1'b1;
            apply_tgt = win_target;
          end else if (pend_valid_q) begin
            apply_en  = 1'b1;
            apply_tgt = pend_target_q;
          end else begin
            pc_d = pc_q + STEP;
          end
        end else if (any_valid && (!pend_valid_q || win_idx < pend_idx_q)) begin
          pend_valid_d  = 1'b1;
          pend_idx_d    = win_idx;
          pend_target_d = win_target;
        end
      end
      default: state_d = BOOT;
    endcase

    if (apply_en) begin
      pc_d       = apply_tgt & ~LOW_MASK;
      epoch_d    = ~epoch_q;
      misalign_d = |(apply_tgt & LOW_MASK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      epoch_q       <= 1'b0;
      misalign_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_idx_q    <= '0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      epoch_q       <= epoch_d;
      misalign_q    <= misalign_d;
      pend_valid_q  <= pend_valid_d;
      pend_idx_q    <= pend_idx_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign epoch    = epoch_q;
  assign misalign = misalign_q;

endmodule
